// File: rtl/tug_pkg.sv
// Shared types and 7-segment glyphs for the tug-of-war match logic.
// The segment constants are also used by the round-victory display.
package tug_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PLAY  = 3'd1,
    ST_HOLD  = 3'd2,
    ST_CLEAR = 3'd3,
    ST_DONE  = 3'd4
  } tug_state_e;

  // Active-low segments, bit order gfedcba
  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_7   = 7'b1111000;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

endpackage

// File: rtl/tug_match_controller_if.sv
// Signal bundle between the match controller and the playfield/buttons/display.
// The slave side is the controller; the master side is whatever drives the buttons.
interface tug_match_controller_if;
  logic       start;
  logic       roundWinL;
  logic       roundWinR;
  logic       fieldReset;
  logic       playEnable;
  logic [2:0] scoreL;
  logic [2:0] scoreR;
  logic [6:0] HEX1;
  logic [6:0] HEX2;
  logic       matchOver;
  logic       matchWinnerL;

  modport master (
    output start, roundWinL, roundWinR,
    input  fieldReset, playEnable, scoreL, scoreR, HEX1, HEX2, matchOver, matchWinnerL
  );

  modport slave (
    input  start, roundWinL, roundWinR,
    output fieldReset, playEnable, scoreL, scoreR, HEX1, HEX2, matchOver, matchWinnerL
  );
endinterface

// File: rtl/score_seg7.sv
// Combinational 3-bit score to active-low 7-segment digit decoder.
module score_seg7
  import tug_pkg::*;
(
  input  logic [2:0] i_val,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_OFF;
    case (i_val)
      3'd0: o_seg = SEG_0;
      3'd1: o_seg = SEG_1;
      3'd2: o_seg = SEG_2;
      3'd3: o_seg = SEG_3;
      3'd4: o_seg = SEG_4;
      3'd5: o_seg = SEG_5;
      3'd6: o_seg = SEG_6;
      3'd7: o_seg = SEG_7;
      default: o_seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/tug_match_controller.sv
// Best-of-N match sequencer: scores rounds, holds each result on screen,
// clears the playfield between rounds and declares the match winner.
module tug_match_controller
  import tug_pkg::*;
#(
  parameter int WIN_ROUNDS  = 3,
  parameter int HOLD_CYCLES = 8
) (
  input  logic                   clk,
  input  logic                   Reset,
  tug_match_controller_if.slave  bus
);

  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_PLAY  = ST_PLAY;
  localparam logic [2:0] S_HOLD  = ST_HOLD;
  localparam logic [2:0] S_CLEAR = ST_CLEAR;
  localparam logic [2:0] S_DONE  = ST_DONE;

  localparam logic [2:0] WIN_VAL   = 3'(WIN_ROUNDS);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  logic [2:0] r_state;
  logic [7:0] r_hold_cnt;
  logic       r_start_q;
  logic [2:0] r_score_l;
  logic [2:0] r_score_r;
  logic       r_winner_l;

  logic       w_start_edge;
  logic       w_win_l;
  logic       w_win_r;
  logic       w_decided;
  logic [6:0] w_hex_l;
  logic [6:0] w_hex_r;

  assign w_start_edge = bus.start & ~r_start_q;
  assign w_win_l      = bus.roundWinL & ~bus.roundWinR;
  assign w_win_r      = bus.roundWinR & ~bus.roundWinL;
  assign w_decided    = (r_score_l == WIN_VAL) || (r_score_r == WIN_VAL);

  always_ff @(posedge clk) begin
    if (!Reset) begin
      r_state    <= S_IDLE;
      r_hold_cnt <= '0;
      r_start_q  <= 1'b0;
      r_score_l  <= '0;
      r_score_r  <= '0;
      r_winner_l <= 1'b0;
    end else begin
      r_start_q <= bus.start;
      case (r_state)
        S_IDLE: begin
          if (w_start_edge) r_state <= S_PLAY;
        end
        // A tie still ends the round, but nobody scores and it is replayed
        S_PLAY: begin
          if (bus.roundWinL || bus.roundWinR) begin
            r_state <= S_HOLD;
            if (w_win_l && (r_score_l != WIN_VAL)) r_score_l <= r_score_l + 3'd1;
            if (w_win_r && (r_score_r != WIN_VAL)) r_score_r <= r_score_r + 3'd1;
          end
        end
        S_HOLD: begin
          if (r_hold_cnt == HOLD_LAST) begin
            r_hold_cnt <= '0;
            if (w_decided) begin
              r_state    <= S_DONE;
              r_winner_l <= (r_score_l == WIN_VAL);
            end else begin
              r_state <= S_CLEAR;
            end
          end else begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
          end
        end
        S_CLEAR: begin
          r_state <= S_PLAY;
        end
        S_DONE: begin
          if (w_start_edge) begin
            r_score_l  <= '0;
            r_score_r  <= '0;
            r_winner_l <= 1'b0;
            r_state    <= S_CLEAR;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  score_seg7 u_seg_l (.i_val(r_score_l), .o_seg(w_hex_l));
  score_seg7 u_seg_r (.i_val(r_score_r), .o_seg(w_hex_r));

  // Every output is a decode of registered state only
  assign bus.fieldReset   = (r_state == S_IDLE) || (r_state == S_CLEAR);
  assign bus.playEnable   = (r_state == S_PLAY);
  assign bus.matchOver    = (r_state == S_DONE);
  assign bus.matchWinnerL = r_winner_l;
  assign bus.scoreL       = r_score_l;
  assign bus.scoreR       = r_score_r;
  assign bus.HEX2         = w_hex_l;
  assign bus.HEX1         = w_hex_r;

endmodule

// File: tb/tb_tug_match_controller.sv
// Directed plus randomized match sequences for tug_match_controller,
// checked against a round-count model of a best-of-N match.
module tb_tug_match_controller;

  localparam int WR = 3;
  localparam int HC = 4;

  logic clk   = 1'b0;
  logic Reset = 1'b0;

  tug_match_controller_if bus ();

  tug_match_controller #(.WIN_ROUNDS(WR), .HOLD_CYCLES(HC)) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int mL    = 0;
  int mR    = 0;

  logic [6:0] seg_tab [8] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_scores(input string tag);
    chk({tag, "_scoreL"}, 32'(bus.scoreL), mL);
    chk({tag, "_scoreR"}, 32'(bus.scoreR), mR);
    chk({tag, "_HEX2"}, 32'(bus.HEX2), 32'(seg_tab[mL]));
    chk({tag, "_HEX1"}, 32'(bus.HEX1), 32'(seg_tab[mR]));
  endtask

  task automatic chk_ctrl(input string tag, input int fr, input int pe, input int mo);
    chk({tag, "_fieldReset"}, 32'(bus.fieldReset), fr);
    chk({tag, "_playEnable"}, 32'(bus.playEnable), pe);
    chk({tag, "_matchOver"}, 32'(bus.matchOver), mo);
  endtask

  // kind: 0 = left wins, 1 = right wins, 2 = tie. Called while a round is live.
  // The round-win levels stay high like the victory display until fieldReset.
  task automatic play_round(input int kind);
    bus.roundWinL = (kind == 0) || (kind == 2);
    bus.roundWinR = (kind == 1) || (kind == 2);
    tick;
    if (kind == 0 && mL < WR) mL++;
    if (kind == 1 && mR < WR) mR++;
    chk_scores("win");
    chk_ctrl("hold_first", 0, 0, 0);
    for (int i = 1; i < HC; i++) begin
      bus.start = 1'($urandom_range(0, 1));
      tick;
      chk_ctrl("hold", 0, 0, 0);
      chk_scores("hold");
    end
    bus.start = 1'b0;
    tick;
    if (mL == WR || mR == WR) begin
      chk_ctrl("done", 0, 0, 1);
      chk("winner", 32'(bus.matchWinnerL), (mL == WR) ? 1 : 0);
      chk_scores("done");
    end else begin
      chk_ctrl("clear", 1, 0, 0);
      bus.roundWinL = 1'b0;
      bus.roundWinR = 1'b0;
      tick;
      chk_ctrl("replay", 0, 1, 0);
      chk_scores("replay");
    end
  endtask

  task automatic rematch;
    for (int i = 0; i < 3; i++) begin
      bus.roundWinL = 1'($urandom_range(0, 1));
      bus.roundWinR = 1'($urandom_range(0, 1));
      tick;
      chk_ctrl("done_stay", 0, 0, 1);
      chk_scores("done_stay");
    end
    bus.start = 1'b1;
    tick;
    bus.start     = 1'b0;
    bus.roundWinL = 1'b0;
    bus.roundWinR = 1'b0;
    mL = 0;
    mR = 0;
    chk_ctrl("rematch_clear", 1, 0, 0);
    chk_scores("rematch");
    chk("rematch_winner", 32'(bus.matchWinnerL), 0);
    tick;
    chk_ctrl("rematch_play", 0, 1, 0);
  endtask

  task automatic idle_play(input int n);
    for (int i = 0; i < n; i++) begin
      bus.start = 1'($urandom_range(0, 1));
      tick;
      chk_ctrl("idle_play", 0, 1, 0);
      chk_scores("idle_play");
    end
    bus.start = 1'b0;
    tick;
    chk_ctrl("idle_play_end", 0, 1, 0);
  endtask

  initial begin
    int rounds;
    bus.start     = 1'b0;
    bus.roundWinL = 1'b0;
    bus.roundWinR = 1'b0;

    // Reset and idle
    Reset = 1'b0;
    tick;
    tick;
    chk_ctrl("reset", 1, 0, 0);
    chk_scores("reset");
    chk("reset_winner", 32'(bus.matchWinnerL), 0);
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk_ctrl("idle", 1, 0, 0);
    end
    chk_scores("idle");

    // Directed match: left, tie, right, left, start during play, left takes it
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    chk_ctrl("first_play", 0, 1, 0);
    play_round(0);
    play_round(2);
    play_round(1);
    play_round(0);
    idle_play(2);
    play_round(0);
    chk("directed_done", 32'(bus.matchOver), 1);
    rematch;

    // Randomized matches
    for (int m = 0; m < 4; m++) begin
      rounds = 0;
      while (!(mL == WR || mR == WR) && rounds < 30) begin
        idle_play($urandom_range(0, 2));
        play_round($urandom_range(0, 2));
        rounds++;
      end
      chk("rand_match_decided", 32'(bus.matchOver), 1);
      rematch;
    end

    // Reset on the second HOLD cycle
    bus.roundWinL = 1'b1;
    tick;
    tick;
    Reset = 1'b0;
    tick;
    bus.roundWinL = 1'b0;
    mL = 0;
    mR = 0;
    chk_ctrl("hold_reset", 1, 0, 0);
    chk_scores("hold_reset");
    Reset = 1'b1;
    for (int i = 0; i < HC + 2; i++) begin
      tick;
      chk_ctrl("after_hold_reset", 1, 0, 0);
    end
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    chk_ctrl("restart_play", 0, 1, 0);
    play_round(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tug_match_controller.md
Name: tug_match_controller

Overview:
- Sequences a best-of-N tug-of-war match around the existing playfield and round-victory display.
- Counts round wins per player and holds each round result on screen for a fixed time.
- Clears the playfield between rounds and declares the match winner.
- Sits above the playfield and victory logic: drives their active-high reset and gates player input; sees only their round-win levels.

Parameters:
- WIN_ROUNDS, 3: round wins needed to take the match; legal 1..7.
- HOLD_CYCLES, 8: cycles a round result is held before the field clears; legal 2..255.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- Reset  in  1  synchronous, active-low reset; sampled on posedge clk.
- start  in  1  start/rematch button level, already synchronized; rising edge detected internally.
- roundWinL  in  1  level; left player has won the current round; held until the field is reset.
- roundWinR  in  1  level; right player has won the current round.
- fieldReset  out  1  active-high reset to playfield and victory display.
- playEnable  out  1  high only while a round is live; gates L/R key inputs.
- scoreL  out  3  left round-win count.
- scoreR  out  3  right round-win count.
- HEX1  out  7  active-low 7-seg showing scoreR.
- HEX2  out  7  active-low 7-seg showing scoreL.
- matchOver  out  1  match decided.
- matchWinnerL  out  1  1 = left took the match; valid only while matchOver = 1.

Behaviour:
- FSM states: IDLE, PLAY, HOLD, CLEAR, DONE.
- Outputs are decoded from registered state only; there is no combinational path from any input to any output.
- Reset (Reset = 0 at posedge), from any state including mid-HOLD:
  - state = IDLE, scores = 0, hold counter = 0, start edge register = 0, matchWinnerL = 0.
  - Outputs: fieldReset = 1, playEnable = 0, matchOver = 0, HEX1 = HEX2 = 7'b1000000 ("0").
- start edge: start = 1 while the previous sample was 0.
- IDLE:
  - fieldReset = 1, playEnable = 0.
  - start edge -> PLAY on the next cycle.
- PLAY:
  - fieldReset = 0, playEnable = 1.
  - roundWinL & ~roundWinR: scoreL += 1, then -> HOLD.
  - roundWinR & ~roundWinL: scoreR += 1, then -> HOLD.
  - Both high in the same cycle: tie, no score change, -> HOLD (round is replayed).
  - Neither high: stay in PLAY.
  - Scores saturate at WIN_ROUNDS and never wrap.
- HOLD:
  - playEnable = 0, fieldReset = 0; the victory display stays lit.
  - Counter runs 0..HOLD_CYCLES-1, so HOLD lasts exactly HOLD_CYCLES cycles.
  - Exit when counter = HOLD_CYCLES-1: if either score = WIN_ROUNDS -> DONE, else -> CLEAR.
  - Counter clears on exit.
- CLEAR:
  - fieldReset = 1 for exactly one cycle, then -> PLAY.
- DONE:
  - matchOver = 1; matchWinnerL = (scoreL = WIN_ROUNDS), latched on entry.
  - playEnable = 0, fieldReset = 0; scores stay displayed.
  - start edge: scores cleared, matchWinnerL cleared, -> CLEAR.
- start edges in PLAY, HOLD and CLEAR are ignored.
- roundWin inputs are ignored outside PLAY.
- A roundWin level held high across the CLEAR cycle does not re-score: CLEAR resets the playfield, and PLAY samples the inputs from its first cycle.
- Latency: a win sampled at posedge N gives:
  - score updated and HOLD visible at N+1;
  - CLEAR (fieldReset high) at N+1+HOLD_CYCLES;
  - PLAY at N+2+HOLD_CYCLES.
- 7-seg encodings, active-low gfedcba: 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000.

Decomposition:
- Package tug_pkg holds:
  - the state enum type (IDLE, PLAY, HOLD, CLEAR, DONE);
  - the 7-seg digit constants SEG_0..SEG_7 and SEG_OFF = 7'b1111111, shared with the victory display.
- Sub-module score_seg7: combinational 3-bit -> 7-bit active-low decoder, instantiated twice.

Test Plan:
All scenarios use WIN_ROUNDS = 3, HOLD_CYCLES = 4.
1. Reset = 0 for 2 cycles, then Reset = 1 with no start -> fieldReset = 1, playEnable = 0, scores 0, HEX1 = HEX2 = 1000000, state stays IDLE.
2. Start pulse, then roundWinL held high from cycle N -> scoreL = 1 and HEX2 = 1111001 at N+1; playEnable = 0 for 4 cycles; fieldReset = 1 for exactly one cycle at N+5; playEnable = 1 at N+6; no second increment.
3. roundWinL and roundWinR high in the same cycle in PLAY -> scores unchanged; HOLD for 4 cycles, then CLEAR, then PLAY.
4. Left wins 3 rounds with right winning 1 in between -> after the third left win plus 4 HOLD cycles: matchOver = 1, matchWinnerL = 1, scoreL = 3 (HEX2 = 0110000), scoreR = 1, fieldReset stays 0; further roundWin pulses do not change the scores.
5. In DONE, start edge -> scores = 0 and matchOver = 0 next cycle, fieldReset = 1 for one cycle, then PLAY; a start edge during PLAY has no effect.
6. Reset = 0 asserted on the 2nd HOLD cycle -> next posedge shows IDLE with scores 0, fieldReset = 1, counter cleared, and no CLEAR pulse.
